// File: rtl/jmp_cond_unit.sv
// Jump-condition unit: latched flag bank plus saturating loop counter resolve JMP_sel into the J bit for INS.
// Latency: J is combinational; captured flags and counter updates appear after the next clk edge. No backpressure.
module jmp_cond_unit #(
    parameter int NFLAG = 8,
    parameter int IDX_W = 3,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IDX_W+2:0]   JMP_sel,
    input  logic               JMP_en,
    input  logic [NFLAG-1:0]   FLAG_in,
    input  logic [NFLAG-1:0]   FLAG_we,
    input  logic               CNT_ld,
    input  logic [CNT_W-1:0]   CNT_din,
    output logic               J,
    output logic [NFLAG-1:0]   FLAG_q,
    output logic [CNT_W-1:0]   CNT_out,
    output logic               CNT_Z
);

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_JUMP = 3'd1,
        OP_JFS  = 3'd2,
        OP_JNFS = 3'd3,
        OP_JFL  = 3'd4,
        OP_JNFL = 3'd5,
        OP_LOOP = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    op_e              op;
    logic [IDX_W-1:0] idx;
    logic             fs;
    logic             fl;
    logic             cnt_zero;
    logic             cnt_gt1;
    logic             cnt_dec;
    logic             j_raw;

    assign op  = op_e'(JMP_sel[IDX_W+2:IDX_W]);
    assign idx = JMP_sel[IDX_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            FLAG_q <= '0;
        end else begin
            FLAG_q <= (FLAG_q & ~FLAG_we) | (FLAG_in & FLAG_we);
        end
    end

    // Indices beyond the implemented flag bank read as zero on both paths.
    always_comb begin
        fs = 1'b0;
        fl = 1'b0;
        for (int i = 0; i < NFLAG; i++) begin
            if (idx == IDX_W'(i)) begin
                fs = FLAG_q[i];
                fl = FLAG_in[i];
            end
        end
    end

    assign cnt_zero = (CNT_out == '0);
    assign cnt_gt1  = (CNT_out > CNT_W'(1));
    assign cnt_dec  = JMP_en && (op == OP_LOOP) && !cnt_zero;
    assign CNT_Z    = cnt_zero;

    // Load wins over decrement; decrement stops at zero so the loop cannot re-arm by wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            CNT_out <= '0;
        end else if (CNT_ld) begin
            CNT_out <= CNT_din;
        end else if (cnt_dec) begin
            CNT_out <= CNT_out - CNT_W'(1);
        end
    end

    always_comb begin
        j_raw = 1'b0;
        case (op)
            OP_NONE: j_raw = 1'b0;
            OP_JUMP: j_raw = 1'b1;
            OP_JFS:  j_raw = fs;
            OP_JNFS: j_raw = ~fs;
            OP_JFL:  j_raw = fl;
            OP_JNFL: j_raw = ~fl;
            OP_LOOP: j_raw = cnt_gt1;
            OP_RSVD: j_raw = 1'b0;
            default: j_raw = 1'b0;
        endcase
    end

    assign J = j_raw & ~rst;

endmodule

// File: doc/jmp_cond_unit.md
# jmp_cond_unit

Parametrised jump-condition unit for the ABRUTECH processor datapath. It holds a bank of `NFLAG` latched status flags and a loop counter. It resolves the jump-select field of the current microinstruction into the single `J` bit that feeds the INS module's next-address logic. It adds per-flag capture, live-flag bypass, polarity selection and a hardware decrement-and-branch loop counter, so loop-driven jumps no longer need accumulator tests.

## Interface
Parameters:
- `NFLAG`, 8: number of status flags; 1..2**`IDX_W`.
- `IDX_W`, 3: width of the flag-index subfield of `JMP_sel`.
- `CNT_W`, 8: loop counter width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `JMP_sel`  in  3+`IDX_W`  bits [`IDX_W`+2:`IDX_W`] are the opcode `op`; bits [`IDX_W`-1:0] are the flag index `idx`.
- `JMP_en`  in  1  microinstruction execute strobe; gates counter side effects.
- `FLAG_in`  in  `NFLAG`  live status flags from the datapath (AC_Z, ZT, ZRG, ...).
- `FLAG_we`  in  `NFLAG`  per-bit capture enable for the flag register.
- `CNT_ld`  in  1  load the loop counter.
- `CNT_din`  in  `CNT_W`  loop counter load value.
- `J`  out  1  jump decision to INS.
- `FLAG_q`  out  `NFLAG`  latched flag register.
- `CNT_out`  out  `CNT_W`  loop counter value.
- `CNT_Z`  out  1  high when `CNT_out` == 0.

## Operation
- Flag register: on each edge, for every bit i with `FLAG_we`[i]=1, `FLAG_q`[i] <= `FLAG_in`[i]. Bits with `FLAG_we`[i]=0 hold.
- Selected flags:
  - `fs` = `FLAG_q`[`idx`] and `fl` = `FLAG_in`[`idx`].
  - When `idx` >= `NFLAG`, both are 0.
- `J` is combinational from `op`, `fs`, `fl` and `CNT_out`, and is independent of `JMP_en`:
  - 0 NONE: `J`=0.
  - 1 JUMP: `J`=1.
  - 2 JFS: `J`=`fs`.
  - 3 JNFS: `J`=~`fs`.
  - 4 JFL: `J`=`fl`.
  - 5 JNFL: `J`=~`fl`.
  - 6 LOOP: `J`=1 iff `CNT_out` > 1, i.e. the count after decrement is nonzero.
  - 7 reserved: `J`=0.
- Loop counter update:
  - If `CNT_ld`=1, `CNT_out` <= `CNT_din`.
  - Else if `JMP_en`=1, `op`=LOOP and `CNT_out`!=0, `CNT_out` <= `CNT_out`-1.
  - Otherwise it holds.
  - The counter saturates at 0 and never wraps to all-ones.
- Load has priority over decrement in the same cycle.
- A LOOP with counter 0 gives `J`=0 and leaves the counter at 0.
- Loading 1 gives exactly one fall-through: `J`=0, and the counter goes to 0.
- Loading N>=1 and executing LOOP each iteration gives N-1 taken jumps.
- `CNT_Z` = (`CNT_out` == 0), combinational from the register.

## Timing
- Reset, asynchronous, effective immediately: `FLAG_q`=0, `CNT_out`=0, `CNT_Z`=1. `J` is forced to 0 while `rst`=1.
- After reset release, `J` follows the `op` table in the same cycle. For example, `op`=JNFS gives `J`=1 because the flags are 0.
- JFS/JNFS latency: a flag captured at edge k is visible to `J` after edge k. A same-cycle `FLAG_we` with JFS reads the old value.
- JFL/JNFL have zero latency: `J` tracks `FLAG_in` combinationally. This is the only path from `FLAG_in` to `J`.
- LOOP: `J` reflects the pre-decrement `CNT_out`. The decrement lands at the edge ending the `JMP_en` cycle.
- `JMP_en` held low: no state change from LOOP, but `J` is still driven.
- Reset asserted mid-loop clears the counter. The next LOOP falls through.
- There are no handshakes. `JMP_sel` must be stable for the `J` setup to the INS register.

## Test plan
- Reset, then hold `op`=JUMP: `J`=0 while `rst`=1 and `J`=1 after release. `FLAG_q`=0, `CNT_out`=0, `CNT_Z`=1.
- `FLAG_in`=8'hA5 with `FLAG_we`=8'h0F at one edge, then `FLAG_in`=8'hFF with no write: `FLAG_q`=8'h05. JFS idx=2 gives `J`=1; JFS idx=1 gives `J`=0; JNFS idx=7 gives `J`=1.
- JFL idx=3 with `FLAG_in`[3] toggled between edges: `J` follows in the same cycle. Write and JFS in the same cycle: `J` shows the old value, then the new value the next cycle.
- `CNT_din`=3 loaded, then LOOP with `JMP_en`=1 for 4 cycles: `J` sequence is 1,1,0,0 and `CNT_out` sequence is 3,2,1,0,0. `CNT_Z` rises after the third decrement.
- LOOP with `JMP_en`=1 and `CNT_ld`=1, `CNT_din`=5 in the same cycle, counter at 2: the next `CNT_out`=5, with no decrement.
- Parameter sweep `NFLAG`=5, `IDX_W`=3: JFS/JFL/JNFS/JNFL with idx=6 give `J`=0,0,1,1. `op`=7 gives `J`=0.
